// File: rtl/i2s_audio_tx.sv
// rtl/i2s_audio_tx.sv - Philips I2S stereo serializer with fractional BCK/LRCK generation
module i2s_audio_tx #(
  parameter int CLK_RATE   = 32000000,
  parameter int AUDIO_RATE = 48000,
  parameter int AUDIO_DW   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AUDIO_DW-1:0] left_chan,
  input  logic [AUDIO_DW-1:0] right_chan,
  output logic                sample_req,
  output logic                i2s_bck,
  output logic                i2s_lrck,
  output logic                i2s_data
);

  // Two ticks per BCK period, 64 BCK periods per frame.
  localparam int STEP  = 128 * AUDIO_RATE;
  localparam int ACC_W = $clog2(CLK_RATE + STEP + 1);
  localparam logic [ACC_W-1:0] STEP_V = ACC_W'(STEP);
  localparam logic [ACC_W-1:0] CLK_V  = ACC_W'(CLK_RATE);

  // Each BCK half-period must span at least two system clocks.
  generate
    if (CLK_RATE < 256 * AUDIO_RATE) begin : g_rate_check
      $error("i2s_audio_tx: CLK_RATE must be at least 256 x AUDIO_RATE");
    end
    if (AUDIO_DW < 8 || AUDIO_DW > 31) begin : g_width_check
      $error("i2s_audio_tx: AUDIO_DW must be within 8..31");
    end
  endgenerate

  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_sum;
  logic                tick;
  logic                fall;
  logic [5:0]          bitcnt;
  logic [5:0]          bitcnt_nxt;
  logic [4:0]          pos;
  logic [4:0]          idx;
  logic [AUDIO_DW-1:0] lbuf;
  logic [AUDIO_DW-1:0] rbuf;
  logic [AUDIO_DW-1:0] sel_buf;
  logic [31:0]         sel_ext;
  logic                in_word;
  logic                data_nxt;

  // Tick decision, next slot position and the bit that slot position selects.
  always_comb begin
    acc_sum    = acc + STEP_V;
    tick       = (acc_sum >= CLK_V);
    fall       = tick & i2s_bck;
    bitcnt_nxt = bitcnt + 6'd1;
    pos        = bitcnt_nxt[4:0];
    idx        = 5'(AUDIO_DW) - pos;
    sel_buf    = bitcnt_nxt[5] ? rbuf : lbuf;
    sel_ext    = 32'(sel_buf);
    in_word    = (pos != 5'd0) && (int'(pos) <= AUDIO_DW);
    data_nxt   = in_word & sel_ext[idx];
  end

  // Fractional accumulator: exact long-term tick rate, at most 1 clk of jitter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (tick) begin
      acc <= acc_sum - CLK_V;
    end else begin
      acc <= acc_sum;
    end
  end

  // Bit clock toggles on every tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i2s_bck <= 1'b0;
    end else if (tick) begin
      i2s_bck <= ~i2s_bck;
    end
  end

  // Frame sequencing on BCK falling edges: word select, data, and sample latch at slot 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitcnt     <= 6'd63;
      i2s_lrck   <= 1'b0;
      i2s_data   <= 1'b0;
      sample_req <= 1'b0;
      lbuf       <= '0;
      rbuf       <= '0;
    end else begin
      sample_req <= 1'b0;
      if (fall) begin
        bitcnt   <= bitcnt_nxt;
        i2s_lrck <= bitcnt_nxt[5];
        i2s_data <= data_nxt;
        if (bitcnt_nxt == 6'd0) begin
          lbuf       <= left_chan;
          rbuf       <= right_chan;
          sample_req <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb/tb_i2s_audio_tx.sv - randomized model-checked bench for i2s_audio_tx
module tb_i2s_audio_tx;

  logic        clk;
  logic        reset;
  logic [31:0] lin [3];
  logic [31:0] rin [3];
  logic [2:0]  sreq;
  logic [2:0]  bck_o;
  logic [2:0]  lrck_o;
  logic [2:0]  dat_o;

  int cr [3] = '{512, 600, 512};
  int dw [3] = '{16, 16, 24};

  int checks = 0;
  int errors = 0;

  // Model state, one entry per DUT
  longint      mk [3];
  int          mn [3];
  logic        mfall [3];
  logic        e_bck [3];
  logic        e_lrck [3];
  logic        e_dat [3];
  logic        e_req [3];
  logic [31:0] lat_l [3];
  logic [31:0] lat_r [3];

  logic [63:0] cap [3];
  logic [63:0] last_frame [3];
  int          frame_done [3];
  longint      last_req;
  longint      last_tog;
  logic        prev_bck1;
  int          tog_count;

  i2s_audio_tx #(.CLK_RATE(512), .AUDIO_RATE(1), .AUDIO_DW(16)) dut_a (
    .clk(clk), .reset(reset),
    .left_chan(lin[0][15:0]), .right_chan(rin[0][15:0]),
    .sample_req(sreq[0]), .i2s_bck(bck_o[0]), .i2s_lrck(lrck_o[0]), .i2s_data(dat_o[0])
  );

  i2s_audio_tx #(.CLK_RATE(600), .AUDIO_RATE(1), .AUDIO_DW(16)) dut_b (
    .clk(clk), .reset(reset),
    .left_chan(lin[1][15:0]), .right_chan(rin[1][15:0]),
    .sample_req(sreq[1]), .i2s_bck(bck_o[1]), .i2s_lrck(lrck_o[1]), .i2s_data(dat_o[1])
  );

  i2s_audio_tx #(.CLK_RATE(512), .AUDIO_RATE(1), .AUDIO_DW(24)) dut_c (
    .clk(clk), .reset(reset),
    .left_chan(lin[2][23:0]), .right_chan(rin[2][23:0]),
    .sample_req(sreq[2]), .i2s_bck(bck_o[2]), .i2s_lrck(lrck_o[2]), .i2s_data(dat_o[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: actual %0h required %0h (t=%0t)", nm, d, act, exp, $time);
    end
  endtask

  // Closed-form model: after k clocks out of reset there have been floor(k*128/CLK_RATE)
  // ticks, half as many BCK falls, and fall F (1-based) carries frame slot (F-1) mod 64.
  task automatic model_update(input int d);
    longint t, tp, f, fp;
    int n, p;
    logic [31:0] w;
    if (reset) begin
      mk[d] = 0; mn[d] = -1; mfall[d] = 1'b0;
      e_bck[d] = 1'b0; e_lrck[d] = 1'b0; e_dat[d] = 1'b0; e_req[d] = 1'b0;
      cap[d] = '0;
    end else begin
      mk[d]++;
      t  = (mk[d] * 128) / cr[d];
      tp = ((mk[d] - 1) * 128) / cr[d];
      f  = t / 2;
      fp = tp / 2;
      e_bck[d] = t[0];
      mfall[d] = (f != fp);
      e_req[d] = 1'b0;
      if (f == 0) begin
        mn[d] = -1; e_lrck[d] = 1'b0; e_dat[d] = 1'b0;
      end else begin
        n = int'((f - 1) % 64);
        mn[d] = n;
        if (mfall[d] && n == 0) begin
          lat_l[d] = lin[d];
          lat_r[d] = rin[d];
          e_req[d] = 1'b1;
        end
        e_lrck[d] = (n >= 32);
        p = n % 32;
        w = (n < 32) ? lat_l[d] : lat_r[d];
        e_dat[d] = (p >= 1 && p <= dw[d]) ? w[dw[d] - p] : 1'b0;
      end
    end
  endtask

  task automatic compare(input int d);
    longint iv;
    chk("bck", d, 64'(bck_o[d]), 64'(e_bck[d]));
    chk("lrck", d, 64'(lrck_o[d]), 64'(e_lrck[d]));
    chk("data", d, 64'(dat_o[d]), 64'(e_dat[d]));
    chk("sample_req", d, 64'(sreq[d]), 64'(e_req[d]));
    if (mfall[d] && mn[d] >= 0) begin
      cap[d][63 - mn[d]] = dat_o[d];
      if (mn[d] == 63) begin
        last_frame[d] = cap[d];
        frame_done[d]++;
      end
    end
    if (d == 0 && sreq[0] === 1'b1) begin
      if (last_req < 0) chk("first_req_clk", 0, 64'(mk[0]), 64'd8);
      else chk("req_period", 0, 64'(mk[0] - last_req), 64'd512);
      last_req = mk[0];
    end
    if (d == 1 && !reset && bck_o[1] !== prev_bck1) begin
      if (last_tog > 0) begin
        iv = mk[1] - last_tog;
        chk("tick_interval_4_or_5", 1, 64'(iv == 4 || iv == 5), 64'd1);
        tog_count++;
      end
      last_tog = mk[1];
      prev_bck1 = bck_o[1];
    end
    if (reset) begin
      if (d == 0) last_req = -1;
      if (d == 1) begin last_tog = 0; prev_bck1 = 1'b0; end
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_update(d);
    @(negedge clk);
    for (int d = 0; d < 3; d++) compare(d);
  endtask

  task automatic wait_frame(input int d);
    int start;
    int b;
    start = frame_done[d];
    b = 0;
    while (frame_done[d] == start && b < 2000) begin
      step();
      b++;
    end
    chk("frame_timeout", d, 64'(b < 2000), 64'd1);
  endtask

  task automatic wait_slot(input int d, input int n);
    int b;
    b = 0;
    while (!(mfall[d] && mn[d] == n) && b < 2000) begin
      step();
      b++;
    end
    chk("slot_timeout", d, 64'(b < 2000), 64'd1);
  endtask

  task automatic check_all_zero(input string nm);
    for (int d = 0; d < 3; d++) begin
      chk(nm, d, {60'd0, sreq[d], bck_o[d], lrck_o[d], dat_o[d]}, 64'd0);
    end
  endtask

  initial begin
    reset = 1'b0;
    last_req = -1; last_tog = 0; prev_bck1 = 1'b0; tog_count = 0;
    for (int d = 0; d < 3; d++) begin
      frame_done[d] = 0; cap[d] = '0; last_frame[d] = '0;
      lat_l[d] = '0; lat_r[d] = '0; mk[d] = 0; mn[d] = -1; mfall[d] = 1'b0;
      lin[d] = $urandom; rin[d] = $urandom;
    end
    lin[0] = 32'h0000A5C3; rin[0] = 32'h00008001;
    lin[2] = 32'h00800001;

    #2 reset = 1'b1;
    #1 check_all_zero("reset_state");
    repeat (3) step();
    reset = 1'b0;

    // First frame: literal bit patterns of both slots
    wait_frame(0);
    chk("frame_a5c3_8001", 0, last_frame[0],
        {1'b0, 16'hA5C3, 15'd0, 1'b0, 16'h8001, 15'd0});
    chk("left24_800001", 2, {32'd0, last_frame[2][63:32]}, {32'd0, 1'b0, 24'h800001, 7'd0});

    // Input change mid-frame only affects the following frame
    lin[0] = 32'h0;
    wait_slot(0, 5);
    lin[0] = 32'h0000FFFF;
    wait_frame(0);
    chk("left_before_change", 0, {32'd0, last_frame[0][63:32]}, 64'd0);
    wait_frame(0);
    chk("left_after_change", 0, {32'd0, last_frame[0][63:32]}, {32'd0, 1'b0, 16'hFFFF, 15'd0});

    // Randomized inputs every clock; the model decides what each frame must carry
    for (int i = 0; i < 5000; i++) begin
      step();
      for (int d = 0; d < 3; d++) begin
        lin[d] = $urandom;
        rin[d] = $urandom;
      end
    end
    chk("tick_intervals_seen", 1, 64'(tog_count >= 1000), 64'd1);

    // Reset in the middle of the right slot
    wait_slot(0, 40);
    reset = 1'b1;
    #1 check_all_zero("async_reset");
    repeat (3) step();
    lin[0] = 32'h00001234; rin[0] = 32'h00004321;
    reset = 1'b0;
    wait_frame(0);
    chk("frame_after_reset", 0, last_frame[0],
        {1'b0, 16'h1234, 15'd0, 1'b0, 16'h4321, 15'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
